// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: widths, opcode encodings,
// the boot program image and the responder FSM state type.
package mem_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    localparam logic [3:0] OP_HALT     = 4'b0000;
    localparam logic [3:0] OP_NOP      = 4'b0011;
    localparam logic [3:0] OP_LOAD_B   = 4'b0001;
    localparam logic [3:0] OP_LOAD_A   = 4'b0010;
    localparam logic [3:0] OP_STORE_A  = 4'b0100;
    localparam logic [3:0] OP_ADD      = 4'b1000;
    localparam logic [3:0] OP_SUB      = 4'b1001;
    localparam logic [3:0] OP_JUMP     = 4'b1010;
    localparam logic [3:0] OP_JUMP_NEG = 4'b1011;

    localparam logic [DATA_W_DEF-1:0] BOOT_IMAGE [16] = '{
        8'h2E, 8'h1F, 8'h84, 8'hA2,
        8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h01, 8'h01
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RSP_I = 2'd1,
        RSP_D = 2'd2
    } state_t;

    // Words beyond the 16-entry image boot as zero.
    function automatic logic [DATA_W_DEF-1:0] boot_word(input int idx);
        if (idx >= 0 && idx < 16)
            return BOOT_IMAGE[idx];
        return '0;
    endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage with one registered read port and one write port;
// rst reloads the boot image. A read coinciding with a write returns the new data.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Reset wins over a write on the same edge, so a store racing rst is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= DATA_W'(boot_word(i));
            rd_data <= '0;
        end else begin
            if (we)
                mem[addr] <= wdata;
            if (rd_en)
                rd_data <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder serving an instruction-fetch port and a data port, one access
// at a time with data priority. Optional store protection: MEM_RESPONDER_WRITE_PROTECT_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH      = 16,
    parameter int PROT_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              d_rsp_err
);

`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    state_t            state;
    logic              if_vld_r;
    logic              d_vld_r;
    logic              err_r;
    logic [DATA_W-1:0] if_hold;
    logic [DATA_W-1:0] d_hold;
    logic              if_acc;
    logic              d_acc;
    logic              prot_hit;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] rd_data;

    assign d_req_ready  = (state == IDLE) && !rst;
    assign if_req_ready = (state == IDLE) && !rst && !d_req_valid;
    assign d_acc        = d_req_valid && d_req_ready;
    assign if_acc       = if_req_valid && if_req_ready;

    assign prot_hit = PROT_ON && d_req_we && (d_req_addr < ADDR_W'(PROT_LIMIT));
    assign arr_addr = d_acc ? d_req_addr : if_req_addr;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (d_acc || if_acc),
        .addr    (arr_addr),
        .we      (d_acc && d_req_we && !prot_hit),
        .wdata   (d_req_wdata),
        .rd_data (rd_data)
    );

    // A response pending when rst arrives is dropped rather than pulsed.
    assign if_rsp_valid = if_vld_r && !rst;
    assign d_rsp_valid  = d_vld_r && !rst;
    assign d_rsp_err    = err_r;

    // The array register carries data during the response cycle; holds keep it afterwards.
    assign if_rsp_data = (state == RSP_I) ? rd_data : if_hold;
    assign d_rsp_data  = (state == RSP_D) ? rd_data : d_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            if_vld_r <= 1'b0;
            d_vld_r  <= 1'b0;
            err_r    <= 1'b0;
            if_hold  <= '0;
            d_hold   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_acc) begin
                        state   <= RSP_D;
                        d_vld_r <= 1'b1;
                        err_r   <= prot_hit;
                    end else if (if_acc) begin
                        state    <= RSP_I;
                        if_vld_r <= 1'b1;
                    end
                end
                RSP_I: begin
                    state    <= IDLE;
                    if_vld_r <= 1'b0;
                    if_hold  <= rd_data;
                end
                RSP_D: begin
                    state   <= IDLE;
                    d_vld_r <= 1'b0;
                    err_r   <= 1'b0;
                    d_hold  <= rd_data;
                end
                default: begin
                    state    <= IDLE;
                    if_vld_r <= 1'b0;
                    d_vld_r  <= 1'b0;
                    err_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder: boot image, fetch/load/store, arbitration,
// reset during a response and (when MEM_RESPONDER_WRITE_PROTECT_EN is set) store protection.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       if_req_valid;
    logic       if_req_ready;
    logic [3:0] if_req_addr;
    logic       if_rsp_valid;
    logic [7:0] if_rsp_data;
    logic       d_req_valid;
    logic       d_req_ready;
    logic       d_req_we;
    logic [3:0] d_req_addr;
    logic [7:0] d_req_wdata;
    logic       d_rsp_valid;
    logic [7:0] d_rsp_data;
    logic       d_rsp_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_we     (d_req_we),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .d_rsp_err    (d_rsp_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] addr, input logic [7:0] exp);
        if_req_valid = 1'b1;
        if_req_addr  = addr;
        #1;
        checks++;
        if (if_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL fetch_ready addr=%0d got=%b want=1", addr, if_req_ready);
        end
        tick();
        if_req_valid = 1'b0;
        checks++;
        if (if_rsp_valid !== 1'b1 || if_rsp_data !== exp || d_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_rsp addr=%0d got vld=%b data=%h dvld=%b want vld=1 data=%h dvld=0",
                     addr, if_rsp_valid, if_rsp_data, d_rsp_valid, exp);
        end
        tick();
        checks++;
        if (if_rsp_valid !== 1'b0 || if_rsp_data !== exp) begin
            failures++;
            $display("FAIL fetch_hold addr=%0d got vld=%b data=%h want vld=0 data=%h",
                     addr, if_rsp_valid, if_rsp_data, exp);
        end
    endtask

    task automatic d_access(input logic we, input logic [3:0] addr, input logic [7:0] wdata,
                            input logic [7:0] exp, input logic exp_err);
        d_req_valid = 1'b1;
        d_req_we    = we;
        d_req_addr  = addr;
        d_req_wdata = wdata;
        #1;
        checks++;
        if (d_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL d_ready we=%b addr=%0d got=%b want=1", we, addr, d_req_ready);
        end
        tick();
        d_req_valid = 1'b0;
        checks++;
        if (d_rsp_valid !== 1'b1 || d_rsp_data !== exp || d_rsp_err !== exp_err
            || if_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL d_rsp we=%b addr=%0d got vld=%b data=%h err=%b want vld=1 data=%h err=%b",
                     we, addr, d_rsp_valid, d_rsp_data, d_rsp_err, exp, exp_err);
        end
        tick();
        checks++;
        if (d_rsp_valid !== 1'b0 || d_rsp_data !== exp || d_rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL d_hold addr=%0d got vld=%b data=%h err=%b want vld=0 data=%h err=0",
                     addr, d_rsp_valid, d_rsp_data, d_rsp_err, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0;
        tick();
        tick();
        checks++;
        if (if_req_ready !== 1'b0 || d_req_ready !== 1'b0 || if_rsp_valid !== 1'b0
            || d_rsp_valid !== 1'b0 || d_rsp_err !== 1'b0
            || if_rsp_data !== 8'h00 || d_rsp_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_state got ifr=%b dr=%b ifv=%b dv=%b err=%b ifd=%h dd=%h want all 0",
                     if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, d_rsp_err,
                     if_rsp_data, d_rsp_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (if_req_ready !== 1'b1 || d_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got ifr=%b dr=%b want 1 1", if_req_ready, d_req_ready);
        end
    endtask

    task automatic test_fetch();
        fetch(4'd0, 8'h2E);
        fetch(4'd3, 8'hA2);
    endtask

    task automatic test_load();
        d_access(1'b0, 4'd14, 8'h00, 8'h01, 1'b0);
        d_access(1'b0, 4'd5,  8'h00, 8'h00, 1'b0);
        d_access(1'b0, 4'd15, 8'h00, 8'h01, 1'b0);
    endtask

    task automatic test_store_raw();
        d_access(1'b1, 4'd13, 8'h5A, 8'h5A, 1'b0);
        d_access(1'b0, 4'd13, 8'h00, 8'h5A, 1'b0);
    endtask

    task automatic test_arbitration();
        if_req_valid = 1'b1; if_req_addr = 4'd1;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 4'd15;
        #1;
        checks++;
        if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL arb_ready got dr=%b ifr=%b want 1 0", d_req_ready, if_req_ready);
        end
        tick();
        d_req_valid = 1'b0;
        #1;
        checks++;
        if (d_rsp_valid !== 1'b1 || d_rsp_data !== 8'h01 || if_rsp_valid !== 1'b0
            || if_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL arb_d_first got dv=%b dd=%h ifv=%b ifr=%b want 1 01 0 0",
                     d_rsp_valid, d_rsp_data, if_rsp_valid, if_req_ready);
        end
        tick();
        checks++;
        if (if_req_ready !== 1'b1 || if_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL arb_if_accept got ifr=%b ifv=%b dv=%b want 1 0 0",
                     if_req_ready, if_rsp_valid, d_rsp_valid);
        end
        tick();
        if_req_valid = 1'b0;
        checks++;
        if (if_rsp_valid !== 1'b1 || if_rsp_data !== 8'h1F || d_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL arb_if_rsp got ifv=%b ifd=%h dv=%b want 1 1F 0",
                     if_rsp_valid, if_rsp_data, d_rsp_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 4'd2;
        if_req_valid = 1'b1; if_req_addr = 4'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (d_rsp_valid !== 1'b1 || d_rsp_data !== 8'h84 || if_rsp_valid !== 1'b0
                || d_req_ready !== 1'b0) begin
                failures++;
                $display("FAIL b2b_rsp k=%0d got dv=%b dd=%h ifv=%b dr=%b want 1 84 0 0",
                         k, d_rsp_valid, d_rsp_data, if_rsp_valid, d_req_ready);
            end
            tick();
            checks++;
            if (d_rsp_valid !== 1'b0 || if_rsp_valid !== 1'b0 || d_req_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_idle k=%0d got dv=%b ifv=%b dr=%b want 0 0 1",
                         k, d_rsp_valid, if_rsp_valid, d_req_ready);
            end
        end
        d_req_valid = 1'b0;
        if_req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 4'd13; d_req_wdata = 8'h77;
        tick();
        d_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (d_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_drop_pulse got dv=%b want 0", d_rsp_valid);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (d_rsp_valid !== 1'b0 || d_rsp_data !== 8'h00 || d_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_after got dv=%b dd=%h dr=%b want 0 00 1",
                     d_rsp_valid, d_rsp_data, d_req_ready);
        end
        d_access(1'b0, 4'd13, 8'h00, 8'h00, 1'b0);
        d_access(1'b0, 4'd0,  8'h00, 8'h2E, 1'b0);
    endtask

    task automatic test_write_protect();
`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
        d_access(1'b1, 4'd2, 8'hFF, 8'h84, 1'b1);
        d_access(1'b0, 4'd2, 8'h00, 8'h84, 1'b0);
        d_access(1'b1, 4'd3, 8'h11, 8'hA2, 1'b1);
        d_access(1'b1, 4'd4, 8'h33, 8'h33, 1'b0);
        d_access(1'b0, 4'd4, 8'h00, 8'h33, 1'b0);
        fetch(4'd2, 8'h84);
`else
        d_access(1'b1, 4'd2, 8'h3C, 8'h3C, 1'b0);
        d_access(1'b0, 4'd2, 8'h00, 8'h3C, 1'b0);
        fetch(4'd2, 8'h3C);
        d_access(1'b1, 4'd4, 8'h33, 8'h33, 1'b0);
        d_access(1'b0, 4'd4, 8'h00, 8'h33, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load();
        test_store_raw();
        test_arbitration();
        test_back_to_back();
        test_reset_mid();
        test_write_protect();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
